igual_comparador: RTL and testbench
===================================

# igual_comparador

Registered equality comparator. On every enabled clock edge it compares two unsigned operands `A` and `B` and registers `F = 1` when they are bit-for-bit equal. It also keeps a sticky mismatch flag and a saturating count of matches. It sits in the datapath checking blocks, where a single-cycle registered equal/not-equal decision is needed.

## Interface
Parameters:
- `WIDTH`, default 3: operand width in bits (≥1).
- `CNT_W`, default 8: width of the match counter (≥1).

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `en`, input, 1: compare strobe; `A` and `B` are sampled only when `en = 1`.
- `A`, input, WIDTH: operand A, unsigned.
- `B`, input, WIDTH: operand B, unsigned.
- `clr`, input, 1: synchronous clear of `mismatch` and `match_count`.
- `F`, output, 1: registered equality result; 1 means A == B.
- `F_valid`, output, 1: `F` holds the result of a compare from the previous cycle.
- `mismatch`, output, 1: sticky flag; set by any enabled compare with A ≠ B.
- `match_count`, output, CNT_W: saturating count of enabled compares with A == B.

## Operation
- Combinational core: `eq = &(A ~^ B)`, i.e. all WIDTH bits equal. No signed or magnitude interpretation.
- `en = 1` at an edge:
  - `F ← eq`.
  - `F_valid ← 1`.
  - If `eq = 0`, `mismatch ← 1`.
  - If `eq = 1` and `match_count` is below all-ones, `match_count` increments.
- `en = 0` at an edge:
  - `F` holds its previous value.
  - `F_valid ← 0`.
  - `mismatch` and `match_count` hold.
- `clr = 1` at an edge: `mismatch ← 0` and `match_count ← 0`. `F` and `F_valid` are unaffected.
- `clr` and `en` both asserted in the same cycle:
  - Clear happens first, then the current compare is applied.
  - Result is `mismatch = ~eq`, and `match_count = 1` if `eq`, otherwise 0.
- Saturation: `match_count` stays at 2^CNT_W − 1. It never wraps.
- X-free: outputs are fully defined after the first reset edge.

## Timing
- Reset (`rst_n = 0` at a rising edge): `F = 0`, `F_valid = 0`, `mismatch = 0`, `match_count = 0`. Reset overrides `en` and `clr`.
- Reset mid-stream discards any compare in the same cycle. The first enabled edge after `rst_n` returns high produces a valid result.
- Latency: exactly 1 cycle from sampled `A`/`B`/`en` to `F`/`F_valid`, and the same for `mismatch`/`match_count`.
- Throughput: one compare per cycle. Back-to-back `en` pulses are fully supported.
- No handshake or backpressure. `F_valid` is a pure one-cycle-delayed copy of `en` (gated by reset).
- Inputs may change every cycle. Only values present at an edge with `en = 1` matter.

## Structure
- Package `igual_pkg` holds:
  - the default widths (`IGUAL_WIDTH = 3`, `IGUAL_CNT_W = 8`);
  - a helper constant for the counter maximum.
- One natural sub-module: `igual_core`, a purely combinational WIDTH-bit equality (`A`, `B` → `eq`). The top level `igual_comparador` registers its output and holds the flag and counter logic.
- All state is in a single `always_ff` on `clk` using synchronous `rst_n`.

## Test plan
- Equal sweep: with `en = 1`, apply `A = B` = 000, 001, 010, 011, 100, 101 on consecutive cycles.
  - Required: `F = 1` and `F_valid = 1` one cycle after each.
  - After the sweep: `match_count = 6`, `mismatch = 0`.
- Unequal cases: apply A=100, B=101, then A=011, B=000.
  - Required: `F = 0` one cycle after each, and `mismatch = 1` sticky from the first.
  - `match_count` is unchanged.
- Hold: after a compare giving `F = 1`, drop `en` and change to A=111, B=000.
  - Required: `F` stays 1, `F_valid = 0`, counters unchanged.
- Clear priority: with `mismatch = 1`, assert `clr` together with `en`, A=B=010.
  - Required: next cycle `mismatch = 0`, `match_count = 1`, `F = 1`.
- Saturation: with `CNT_W = 2`, apply 5 equal compares.
  - Required: `match_count` reads 1, 2, 3, 3, 3.
- Reset: assert `rst_n = 0` for one edge with `en = 1`, A=B.
  - Required: all outputs are 0 after that edge. Normal operation resumes on the next enabled edge.

Source files
------------

// File: rtl/igual_pkg.sv
// -----------------------------------------------------------------------------
// igual_pkg
// Shared defaults for the registered equality comparator.
//   IGUAL_WIDTH   : default operand width in bits
//   IGUAL_CNT_W   : default match counter width in bits
//   IGUAL_CNT_MAX : saturation value of the match counter at the default width
//   cnt_max()     : saturation value for an arbitrary counter width (<= 63)
// -----------------------------------------------------------------------------
package igual_pkg;

    localparam int IGUAL_WIDTH = 3;
    localparam int IGUAL_CNT_W = 8;

    localparam longint unsigned IGUAL_CNT_MAX = (64'd1 << IGUAL_CNT_W) - 64'd1;

    // All-ones value of a counter that is cnt_w bits wide.
    function automatic longint unsigned cnt_max(input int cnt_w);
        return (64'd1 << cnt_w) - 64'd1;
    endfunction

endpackage : igual_pkg

// File: rtl/igual_core.sv
// -----------------------------------------------------------------------------
// igual_core
// Purely combinational WIDTH-bit equality test. Operands are compared
// bit-for-bit; there is no signed or magnitude interpretation.
// Ports:
//   A  : operand A (WIDTH bits)
//   B  : operand B (WIDTH bits)
//   eq : 1 when every bit of A matches the corresponding bit of B
// -----------------------------------------------------------------------------
module igual_core
    import igual_pkg::*;
#(
    parameter int WIDTH = IGUAL_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             eq
);

    // XNOR marks each agreeing bit position; the AND-reduction requires all.
    assign eq = &(A ~^ B);

endmodule : igual_core

// File: rtl/igual_comparador.sv
// -----------------------------------------------------------------------------
// igual_comparador
// Registered equality comparator with a sticky mismatch flag and a saturating
// match counter. One compare per enabled clock edge, one cycle of latency.
// Ports:
//   clk         : clock, all state updates on the rising edge
//   rst_n       : synchronous active-low reset (overrides en and clr)
//   en          : compare strobe; A and B are sampled only when en = 1
//   A, B        : unsigned operands (WIDTH bits)
//   clr         : synchronous clear of mismatch and match_count
//   F           : registered equality result (1 = A == B), held while en = 0
//   F_valid     : en delayed by one cycle; F is fresh when this is 1
//   mismatch    : sticky, set by any enabled compare with A != B
//   match_count : saturating count of enabled compares with A == B
// -----------------------------------------------------------------------------
module igual_comparador
    import igual_pkg::*;
#(
    parameter int WIDTH = IGUAL_WIDTH,
    parameter int CNT_W = IGUAL_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             clr,
    output logic             F,
    output logic             F_valid,
    output logic             mismatch,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             eq;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic             mismatch_next;

    igual_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .A  (A),
        .B  (B),
        .eq (eq)
    );

    // Clear is applied before the compare of the same cycle, so a combined
    // clr+en leaves only the effect of the current compare.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cnt_base      = clr ? '0 : match_count;
        cnt_next      = cnt_base;
        mismatch_next = clr ? 1'b0 : mismatch;
        if (en) begin
            if (eq) begin
                if (cnt_base != CNT_MAX) begin
                    cnt_next = cnt_base + CNT_W'(1);
                end
            end else begin
                mismatch_next = 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            F           <= 1'b0;
            F_valid     <= 1'b0;
            mismatch    <= 1'b0;
            match_count <= '0;
        end else begin
            F_valid     <= en;
            mismatch    <= mismatch_next;
            match_count <= cnt_next;
            if (en) begin
                F <= eq;
            end
        end
    end

endmodule : igual_comparador

// File: tb/tb_igual_comparador.sv
// -----------------------------------------------------------------------------
// tb_igual_comparador
// Drives two comparators from the same stimulus: one at default widths and one
// with a 2-bit match counter to exercise saturation. A behavioural model
// computes the expected outputs; a compare process checks it every cycle, and
// directed checks pin the model with hand-computed values.
// -----------------------------------------------------------------------------
module tb_igual_comparador;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [2:0] a;
    logic [2:0] b;

    logic       f;
    logic       f_valid;
    logic       mismatch;
    logic [7:0] match_count;

    logic       s_f;
    logic       s_f_valid;
    logic       s_mismatch;
    logic [1:0] s_match_count;

    int tests = 0;
    int fails = 0;

    igual_comparador #(.WIDTH(3), .CNT_W(8)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .A           (a),
        .B           (b),
        .clr         (clr),
        .F           (f),
        .F_valid     (f_valid),
        .mismatch    (mismatch),
        .match_count (match_count)
    );

    igual_comparador #(.WIDTH(3), .CNT_W(2)) u_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .A           (a),
        .B           (b),
        .clr         (clr),
        .F           (s_f),
        .F_valid     (s_f_valid),
        .mismatch    (s_mismatch),
        .match_count (s_match_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_known = 1'b0;
    bit m_f, m_v, m_mis;
    int m_cnt8, m_cnt2;

    function automatic int next_cnt(input int cur, input bit c, input bit hit, input int maxv);
        int v;
        v = c ? 0 : cur;
        if (hit && v < maxv) v = v + 1;
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_f     <= 1'b0;
            m_v     <= 1'b0;
            m_mis   <= 1'b0;
            m_cnt8  <= 0;
            m_cnt2  <= 0;
            m_known <= 1'b1;
        end else begin
            m_v    <= en;
            if (en) m_f <= (a == b);
            m_mis  <= (en && a != b) ? 1'b1 : (clr ? 1'b0 : m_mis);
            m_cnt8 <= next_cnt(m_cnt8, clr, en && a == b, 255);
            m_cnt2 <= next_cnt(m_cnt2, clr, en && a == b, 3);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_known) begin
            check("F",             f,             m_f);
            check("F_valid",       f_valid,       m_v);
            check("mismatch",      mismatch,      m_mis);
            check("match_count",   match_count,   m_cnt8);
            check("sat_F",         s_f,           m_f);
            check("sat_mismatch",  s_mismatch,    m_mis);
            check("sat_count",     s_match_count, m_cnt2);
        end
    end

    // Apply one cycle of stimulus, then return shortly after the rising edge.
    task automatic step(input bit r, input bit e, input bit c, input logic [2:0] x, input logic [2:0] y);
        @(negedge clk);
        #1;
        rst_n = r;
        en    = e;
        clr   = c;
        a     = x;
        b     = y;
        @(posedge clk);
        #2;
    endtask

    int sat_exp[6] = '{1, 2, 3, 3, 3, 3};

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;
        a     = 3'd5;
        b     = 3'd5;

        // Reset with an equal compare pending: everything must read 0.
        step(1'b0, 1'b1, 1'b0, 3'd5, 3'd5);
        check("rst_F",        f,           0);
        check("rst_F_valid",  f_valid,     0);
        check("rst_mismatch", mismatch,    0);
        check("rst_count",    match_count, 0);

        // Equal sweep 000..101; 2-bit counter saturates at 3.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 3'(i), 3'(i));
            check("sweep_F",       f,             1);
            check("sweep_F_valid", f_valid,       1);
            check("sweep_sat_cnt", s_match_count, sat_exp[i]);
        end
        check("sweep_count",    match_count, 6);
        check("sweep_mismatch", mismatch,    0);

        // Unequal cases: sticky mismatch, count unchanged.
        step(1'b1, 1'b1, 1'b0, 3'b100, 3'b101);
        check("neq1_F",        f,           0);
        check("neq1_mismatch", mismatch,    1);
        check("neq1_count",    match_count, 6);
        step(1'b1, 1'b1, 1'b0, 3'b011, 3'b000);
        check("neq2_F",        f,           0);
        check("neq2_mismatch", mismatch,    1);
        check("neq2_count",    match_count, 6);

        // Equal compare then hold with en low and differing operands.
        step(1'b1, 1'b1, 1'b0, 3'b111, 3'b111);
        check("eq7_F",     f,           1);
        check("eq7_count", match_count, 7);
        step(1'b1, 1'b0, 1'b0, 3'b111, 3'b000);
        check("hold_F",        f,           1);
        check("hold_F_valid",  f_valid,     0);
        check("hold_count",    match_count, 7);
        check("hold_mismatch", mismatch,    1);

        // Clear together with an equal compare.
        step(1'b1, 1'b1, 1'b1, 3'b010, 3'b010);
        check("clr_en_F",        f,           1);
        check("clr_en_mismatch", mismatch,    0);
        check("clr_en_count",    match_count, 1);

        // Clear together with an unequal compare.
        step(1'b1, 1'b1, 1'b1, 3'b001, 3'b000);
        check("clr_neq_mismatch", mismatch,    1);
        check("clr_neq_count",    match_count, 0);

        // Clear alone: F holds, F_valid drops.
        step(1'b1, 1'b1, 1'b0, 3'b110, 3'b110);
        step(1'b1, 1'b0, 1'b1, 3'b000, 3'b111);
        check("clr_only_F",        f,           1);
        check("clr_only_F_valid",  f_valid,     0);
        check("clr_only_mismatch", mismatch,    0);
        check("clr_only_count",    match_count, 0);

        // Mid-stream reset discards the pending compare.
        step(1'b1, 1'b1, 1'b0, 3'b011, 3'b011);
        step(1'b0, 1'b1, 1'b1, 3'b100, 3'b100);
        check("rst2_F",        f,           0);
        check("rst2_F_valid",  f_valid,     0);
        check("rst2_mismatch", mismatch,    0);
        check("rst2_count",    match_count, 0);

        // First enabled edge after reset produces a valid result.
        step(1'b1, 1'b1, 1'b0, 3'b011, 3'b011);
        check("post_rst_F",       f,           1);
        check("post_rst_F_valid", f_valid,     1);
        check("post_rst_count",   match_count, 1);

        // Back-to-back alternating compares.
        step(1'b1, 1'b1, 1'b0, 3'b101, 3'b100);
        check("b2b_F0", f, 0);
        step(1'b1, 1'b1, 1'b0, 3'b010, 3'b010);
        check("b2b_F1",        f,           1);
        check("b2b_count",     match_count, 2);
        check("b2b_mismatch",  mismatch,    1);

        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_igual_comparador
